// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the M stage and data memory.
//   dmem_req   : request valid (master -> slave)
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : word-aligned byte address
//   dmem_wdata : lane-replicated store data
//   dmem_be    : byte enables, bit i covers bits [8i+7:8i]
//   dmem_ack   : request accepted/completed this cycle (slave -> master)
//   dmem_rdata : read word, valid when dmem_ack
interface memory_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// MIPS memory stage plus MEM/WB pipeline register.
// Issues loads/stores over a req/ack bus, stalls the pipe while a request is
// outstanding, aligns/extends load data and registers the writeback payload.
//   clk, rst_n             : clock, asynchronous active-low reset
//   RegWriteM..WriteRegM   : M-stage controls, address/ALU result, store data
//   dmem                   : data-memory bus (master side)
//   StallM                 : hold F/D/E/M this cycle (combinational)
//   MemErrW                : one-cycle pulse for misaligned access or timeout
//   RegWriteW..WriteRegW   : registered writeback payload
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteM,
    input  logic                  MemToRegM,
    input  logic                  MemWriteM,
    input  logic [1:0]            LoadSizeM,
    input  logic                  LoadSignedM,
    input  logic [31:0]           ALUOutM,
    input  logic [31:0]           WriteDataM,
    input  logic [4:0]            WriteRegM,
    memory_stage_if.master        dmem,
    output logic                  StallM,
    output logic                  MemErrW,
    output logic                  RegWriteW,
    output logic                  MemToRegW,
    output logic [31:0]           ReadDataW,
    output logic [31:0]           ALUOutW,
    output logic [4:0]            WriteRegW
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             req, stall, timeout;
    logic             memop, is_word, is_half, misaligned, go, err;
    logic [1:0]       lane;
    logic [7:0]       rbyte;
    logic [15:0]      rhalf;
    logic [31:0]      load_data;

    // Access decode and alignment check
    assign memop      = MemToRegM | MemWriteM;
    assign is_word    = LoadSizeM[1];
    assign is_half    = (LoadSizeM == 2'b01);
    assign lane       = ALUOutM[1:0];
    assign misaligned = memop & ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
    assign go         = memop & ~misaligned;
    assign err        = misaligned | timeout;

    // Bus payload; M inputs are frozen by the stall, so these stay stable in WAIT
    assign dmem.dmem_we   = MemWriteM;
    assign dmem.dmem_addr = {ALUOutM[31:2], 2'b00};

    always_comb begin
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = WriteDataM;
        if (!is_word) begin
            if (is_half) begin
                dmem.dmem_be    = 4'b0011 << lane;
                dmem.dmem_wdata = {2{WriteDataM[15:0]}};
            end else begin
                dmem.dmem_be    = 4'b0001 << lane;
                dmem.dmem_wdata = {4{WriteDataM[7:0]}};
            end
        end
    end

    // Load lane select and extension
    assign rbyte = dmem.dmem_rdata[{lane, 3'b000} +: 8];
    assign rhalf = dmem.dmem_rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_data = dmem.dmem_rdata;
        if (!is_word) begin
            if (is_half)
                load_data = {{16{LoadSignedM & rhalf[15]}}, rhalf};
            else
                load_data = {{24{LoadSignedM & rbyte[7]}}, rbyte};
        end
    end

    // FSM state and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, request and stall
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req       = 1'b0;
        stall     = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    req = 1'b1;
                    if (!dmem.dmem_ack) begin
                        stall     = 1'b1;
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dmem.dmem_ack) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    stall   = 1'b1;
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset must drop the request and stall immediately, even mid-access
    assign dmem.dmem_req = req & rst_n;
    assign StallM        = stall & rst_n;

    // MEM/WB register: bubble while stalled, error squashes the write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemErrW   <= 1'b0;
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
            WriteRegW <= '0;
        end else if (stall) begin
            MemErrW   <= 1'b0;
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
            WriteRegW <= '0;
        end else begin
            MemErrW   <= err;
            RegWriteW <= RegWriteM & ~err;
            MemToRegW <= MemToRegM & ~err;
            ReadDataW <= (MemToRegM & ~err) ? load_data : '0;
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
        end
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
MIPS pipeline memory (M) stage plus the MEM/WB pipeline register.
- Issues load/store requests to a data memory over a req/ack handshake, which may take several cycles.
- Raises a stall to the hazard unit while a request is outstanding.
- Aligns and extends load data.
- Registers everything the writeback stage consumes: MemToRegW, ReadDataW, ALUOutW, WriteRegW, plus RegWriteW.

Parameters:
TIMEOUT_CYCLES, 255, number of WAIT cycles without dmem_ack before the access is aborted as a bus error (min 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
RegWriteM  input  1  instruction writes the register file
MemToRegM  input  1  instruction is a load
MemWriteM  input  1  instruction is a store (never set together with MemToRegM)
LoadSizeM  input  2  access size: 00 byte, 01 half, 10 word; 11 treated as word
LoadSignedM  input  1  sign-extend sub-word loads (0 = zero-extend)
ALUOutM  input  32  effective address / ALU result
WriteDataM  input  32  store data (right-justified)
WriteRegM  input  5  destination register
dmem_req  output  1  memory request valid
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address {ALUOutM[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables, bit i = bits [8i+7:8i]
dmem_ack  input  1  memory accepted/completed request this cycle
dmem_rdata  input  32  read word, valid when dmem_ack
StallM  output  1  to hazard unit: hold F/D/E/M this cycle
MemErrW  output  1  registered one-cycle pulse: misaligned access or timeout
RegWriteW, MemToRegW  output  1 each  registered controls to writeback
ReadDataW, ALUOutW  output  32 each  registered load data / ALU result
WriteRegW  output  5  registered destination register

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE, timeout counter 0, dmem_req=0.
  - All W outputs and MemErrW = 0.
  - Reset mid-WAIT drops dmem_req immediately; that access is abandoned.
- memop = MemToRegM | MemWriteM.
- Misaligned access: half with ALUOutM[0]=1, or word with ALUOutM[1:0]!=0. It is never requested (dmem_req=0, no stall). Next cycle: MemErrW=1, RegWriteW=0, MemToRegW=0.
- Little-endian lanes, lane = ALUOutM[1:0].
  - Byte: be=0001<<lane, wdata={4{WriteDataM[7:0]}}.
  - Half: be=0011<<lane, wdata={2{WriteDataM[15:0]}}.
  - Word: be=1111, wdata=WriteDataM.
- Load extract: byte/half selected from dmem_rdata by lane, then sign- or zero-extended to 32; word passes through unchanged.
- FSM IDLE:
  - Aligned memop: dmem_req=1 combinationally.
  - If dmem_ack in the same cycle: zero-wait completion, StallM=0, W register captures.
  - Otherwise: StallM=1, go to WAIT, counter=1.
- FSM WAIT:
  - dmem_req=1; addr/we/be/wdata held stable (M inputs are frozen by the stall).
  - On dmem_ack: StallM=0 that cycle, W register captures, return to IDLE.
  - Otherwise StallM=1 and counter increments.
  - If counter reaches TIMEOUT_CYCLES without ack: StallM=0, dmem_req deasserts next cycle, go to IDLE. W gets MemErrW=1, RegWriteW=0, ReadDataW=0.
- dmem_ack while dmem_req=0: ignored.
- W register (1-cycle latency):
  - On each non-stalled cycle, captures RegWriteM, MemToRegM, ALUOutM, WriteRegM, and ReadDataW=extracted load data (0 for non-loads).
  - On a stalled cycle, inserts a bubble: RegWriteW=0, MemToRegW=0, WriteRegW=0, MemErrW=0. ALUOutW and ReadDataW hold.
- Non-memory instructions never stall; they flow with 1-cycle latency.
- Stores: RegWriteW follows RegWriteM (the decoder drives it 0).

Test Plan:
- Reset: assert rst_n=0 during WAIT. Required: dmem_req and StallM drop asynchronously, all W outputs 0, FSM in IDLE after release.
- ALU op: ALUOutM=0x00000010, WriteRegM=8, RegWriteM=1. Required: next cycle ALUOutW=0x10, WriteRegW=8, RegWriteW=1, MemToRegW=0, StallM never 1.
- Signed byte load: addr 0x103, dmem_rdata=0x80FF1234, ack after 3 cycles. Required: StallM high 3 cycles, bubbles in W meanwhile, then ReadDataW=0xFFFFFF80, MemToRegW=1.
- Half store: addr 0x202, WriteDataM=0x0000ABCD, zero-wait ack. Required: dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, no stall.
- Misaligned word load: addr 0x301. Required: dmem_req stays 0, next cycle MemErrW=1 pulse, RegWriteW=0.
- Timeout: TIMEOUT_CYCLES=4, no ack. Required: StallM high exactly 4 cycles, then MemErrW=1, RegWriteW=0, dmem_req low.
